// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and limits for the handshaked pipeline stage.
package pipe_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam int PIPE_OCC_MAX_NOSKID = 1;
  localparam int PIPE_OCC_MAX_SKID   = 2;

  function automatic pipe_occ_t pipe_occ_count(input logic main_valid, input logic skid_valid);
    return pipe_occ_t'({1'b0, main_valid}) + pipe_occ_t'({1'b0, skid_valid});
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry skid holding register with its valid bit.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Clear wins over write so a flushed cycle never leaves a stale entry behind.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
    end else if (rd_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage register with flush and backpressure.
// PIPE_STAGE_SKID_EN adds a skid entry and registers in_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_occ_t        occupancy
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic             skid_wr, skid_rd;
  logic [WIDTH-1:0] skid_data;

  // The skid only catches an input accepted while the main entry is stalled.
  assign skid_wr = in_fire & valid_q & ~out_ready & ~flush;
  assign skid_rd = out_fire & skid_valid;

  pipe_skid_buf #(
    .WIDTH    (WIDTH),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .wr_i      (skid_wr),
    .wr_data_i (in_data),
    .rd_i      (skid_rd),
    .valid_o   (skid_valid),
    .data_o    (skid_data)
  );

  assign in_ready = ~skid_valid;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (skid_rd) begin
      valid_d = 1'b1;
      data_d  = skid_data;
    end else if (in_fire && (!valid_q || out_ready)) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  assign occupancy = pipe_occ_count(valid_q, skid_valid);
`else
  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  assign occupancy = pipe_occ_count(valid_q, 1'b0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for pipe_stage_hs, both with and without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;

  localparam int          W        = 32;
  localparam logic [31:0] RST_VAL  = 32'h0BAD_F00D;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          OCC_MAX  = 2;
`else
  localparam int          OCC_MAX  = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int            n_vec = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];

  pipe_stage_hs #(
    .WIDTH    (W),
    .RST_DATA (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares what the DUT presents against the queue of accepted entries.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      exp_q.delete();
    end else begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      check("occ_bound", 32'(occupancy <= 2'(OCC_MAX)), 32'd1);
`ifdef PIPE_STAGE_SKID_EN
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
`else
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));
`endif
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Offers vals in order with out_ready held; returns how many were accepted.
  task automatic offer(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                       input int cycles, input int start, output int accepted);
    logic [31:0] vals[3];
    logic        acc;
    vals[0] = v0;
    vals[1] = v1;
    vals[2] = v2;
    accepted = start;
    for (int c = 0; c < cycles && accepted < 3; c++) begin
      in_valid = 1'b1;
      in_data  = vals[accepted];
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) accepted++;
    end
  endtask

  int n_acc;

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Reset asserted mid-stream while an entry is held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", out_data, RST_VAL);
    check("async_rst_occ", 32'(occupancy), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    tick();

    // Streaming: one entry per cycle, one cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + 32'(i);
      @(negedge clk);
      check("stream_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_data", out_data, 32'h10 + 32'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last", out_data, 32'h17);
    tick();
    drain();

    // Backpressure: 0xA1..0xA3 offered against a stalled sink
    out_ready = 1'b0;
    offer(32'hA1, 32'hA2, 32'hA3, 3, 0, n_acc);
    @(negedge clk);
    check("bp_accepted", 32'(n_acc), 32'(OCC_MAX));
    check("bp_occupancy", 32'(occupancy), 32'(OCC_MAX));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", out_data, 32'hA1);
    tick();
    out_ready = 1'b1;
    offer(32'hA1, 32'hA2, 32'hA3, 10, n_acc, n_acc);
    check("bp_all_sent", 32'(n_acc), 32'd3);
    drain();

    // Stability under stall while in_data toggles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      @(negedge clk);
      check("stable_valid", 32'(out_valid), 32'd1);
      check("stable_data", out_data, 32'h55);
      tick();
    end
    drain();

    // Flush with a competing input that must be discarded
    out_ready = 1'b0;
    offer(32'hB1, 32'hB2, 32'hB3, 3, 0, n_acc);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    @(negedge clk);
    check("flush_pre_occ", 32'(occupancy), 32'(OCC_MAX));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_dead", 32'(out_valid), 32'd0);
      tick();
    end

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
